lfsr_rx_checker: RTL
====================

// Module: lfsr_rx_checker
// PURPOSE
//  Receive-side companion to the 8-bit LFSR serial generator: deserialises the LSB-first
//  bit stream (in_bit/in_valid), presents each completed word, and checks it against a local
//  copy of the same LFSR sequence. Sits at the link sink for BIST/PRBS checks; counts errors.
// PARAMETERS
//  WIDTH           8      word/LFSR width; only 8 is supported (taps/feedback defined for 8)
//  TAPS            8'hAA  Galois tap mask; bit i=1 -> next[i] = cur[i-1] ^ fb
//  STEPS_PER_WORD  1      LFSR advances between words (1..8); must match the generator setup
// PORTS
//  clock      in   1  single clock, rising edge
//  reset      in   1  asynchronous, active-low
//  Seed       in   8  seed; sampled while reset is low and on clear
//  clear      in   1  sync: abort partial word, reload expected from Seed, zero err_count
//  in_bit     in   1  serial data, LSB of each word first
//  in_valid   in   1  in_bit qualifier; gaps between bits are allowed
//  data_out   out  8  last completed word
//  word_valid out  1  one-cycle pulse: data_out/match updated
//  match      out  1  data_out == expected word (valid with word_valid)
//  err_count  out  8  mismatched-word count, saturates at 8'hFF
//  locked     out  1  checker in sync (see CONFIGURATION)
// BEHAVIOUR
//  - Step function: fb = (~|cur[6:0]) ^ cur[7]; next[0] = fb;
//    next[i] = TAPS[i] ? cur[i-1]^fb : cur[i-1] (i=1..7). 8'h01->8'h02, 8'h00->8'hAB.
//  - Reset values: data_out=0, word_valid=0, match=0, err_count=0, locked=1, bit_cnt=0,
//    shreg=0, expected = step^STEPS_PER_WORD(Seed). Reset mid-word discards partial bits.
//  - FSM (2 states): IDLE (bit_cnt==0) -> RECV on first in_valid; RECV counts bits 1..7;
//    8th sampled bit completes word and returns to IDLE. bit_cnt 3-bit, wraps 7->0.
//  - Shift: each in_valid edge, shreg <= {in_bit, shreg[7:1]} (LSB-first arrival).
//  - Completion (edge sampling 8th bit): word = {in_bit, shreg[7:1]}; same edge registers
//    data_out=word, match=(word==expected), word_valid=1; visible next cycle, 1-cycle pulse.
//    expected <= step^STEPS_PER_WORD(expected) (single-cycle unrolled advance, no stall).
//  - Mismatch: err_count += 1 unless already 8'hFF (holds at 255).
//  - No in_valid: all state holds; word_valid=0.
//  - clear && in_valid same cycle: clear wins, bit discarded; bit_cnt=0, shreg=0,
//    expected = step^STEPS_PER_WORD(Seed), err_count=0, locked=1; data_out/match hold.
//  - back-to-back words (in_valid continuous): word_valid every 8th cycle, no bubble.
// CONFIGURATION
//  LFSR_RX_SELF_SYNC_EN defined: on a mismatch, locked<=0 and expected <=
//    step^STEPS_PER_WORD(received word) (re-seed from stream); next matching word sets
//    locked<=1. Errors still counted while unlocked.
//  Not defined: expected advances from its own value regardless of mismatch; locked tied 1.
// STRUCTURE
//  - Shared package lfsr_pkg: LFSR_WIDTH=8, LFSR_TAPS=8'hAA, function lfsr_step(cur)
//    (also to be used by the generator so both ends share one definition).
//  - Sub-module lfsr_advance #(STEPS): combinational, out = lfsr_step applied STEPS times;
//    instantiated twice (expected advance, Seed/re-seed load path).
//  - Top: FSM + bit counter, shift register, compare/err counter, optional sync logic.
// TESTING
//  1 Seed=8'h01, K=1: reset, send 8'h02 LSB-first (0,1,0,0,0,0,0,0) -> one cycle after
//    8th bit word_valid=1, data_out=8'h02, match=1, err_count=0; next expected 8'h04.
//  2 Seed=8'h00, K=1: send 8'hAB with in_valid gaps of 3 cycles -> data_out=8'hAB, match=1;
//    word_valid only after 8th valid bit.
//  3 Seed=8'h01: send 8'h03 -> match=0, err_count=1; then 8'h04 -> match=1 (no-SYNC build)
//    or match=0/locked=0 then 8'h06 -> match=1, locked=1 (SYNC build, re-seeded from 8'h03).
//  4 Force 300 mismatching words -> err_count stops at 8'hFF, no wrap.
//  5 Send 5 bits, assert clear together with 6th in_valid -> partial word dropped; following
//    full 8'h02 (Seed=8'h01) -> match=1, err_count=0.
//  6 Drop reset after 4 bits mid-word -> all outputs at reset values; next full word checked
//    against step(Seed) from the new Seed value.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the serial PRBS generator and its receive-side checker.
// Both ends call lfsr_step so the sequence is defined in exactly one place.
//   LFSR_WIDTH : word/LFSR width (only 8 is defined)
//   LFSR_TAPS  : Galois tap mask, bit i set -> next[i] = cur[i-1] ^ fb
//   rx_state_e : checker receive FSM states
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH = 8;
  localparam logic [7:0]  LFSR_TAPS  = 8'hAA;

  typedef enum logic [0:0] {
    StIdle,
    StRecv
  } rx_state_e;

  // Feedback includes the all-zero-low-bits term so 8'h00 is not a lock-up state.
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur,
                                           input logic [7:0] taps = LFSR_TAPS);
    logic       fb;
    logic [7:0] nxt;
    fb     = (~|cur[6:0]) ^ cur[7];
    nxt[0] = fb;
    for (int i = 1; i < 8; i++) begin
      nxt[i] = taps[i] ? (cur[i-1] ^ fb) : cur[i-1];
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational multi-step LFSR advance: state_o = lfsr_step applied STEPS times to state_i.
//   state_i : current LFSR state
//   state_o : state after STEPS steps
module lfsr_advance
  import lfsr_pkg::*;
#(
  parameter int unsigned STEPS = 1,
  parameter logic [7:0]  TAPS  = LFSR_TAPS
) (
  input  logic [7:0] state_i,
  output logic [7:0] state_o
);

  logic [7:0] s;

  always_comb begin
    s = state_i;
    for (int unsigned i = 0; i < STEPS; i++) begin
      s = lfsr_step(s, TAPS);
    end
    state_o = s;
  end

endmodule

// File: rtl/lfsr_rx_checker.sv
// Receive-side PRBS checker: deserialises an LSB-first bit stream, presents each completed
// word and compares it against a local copy of the generator's LFSR sequence.
// Optional feature macro: LFSR_RX_SELF_SYNC_EN (re-seed expected sequence from the stream
// on a mismatch and report lock status).
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset
//   Seed       : LFSR seed, sampled while reset is low and on clear
//   clear      : synchronous abort/reload, zeroes err_count
//   in_bit     : serial data, LSB first
//   in_valid   : in_bit qualifier
//   data_out   : last completed word
//   word_valid : one-cycle pulse when data_out/match update
//   match      : data_out equalled the expected word
//   err_count  : saturating mismatch count
//   locked     : checker in sync with the stream
module lfsr_rx_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH          = LFSR_WIDTH,
  parameter logic [7:0]  TAPS           = LFSR_TAPS,
  parameter int unsigned STEPS_PER_WORD = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] Seed,
  input  logic             clear,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             word_valid,
  output logic             match,
  output logic [7:0]       err_count,
  output logic             locked
);

  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [7:0]       err_q, err_d;
  logic [WIDTH-1:0] data_out_q;
  logic             match_q;
  logic             word_valid_q;

  logic [WIDTH-1:0] word;
  logic             complete;
  logic             word_match;
  logic [WIDTH-1:0] expected_adv;
  logic [WIDTH-1:0] load_src;
  logic [WIDTH-1:0] load_adv;

  assign word       = {in_bit, shreg_q[WIDTH-1:1]};
  assign complete   = in_valid && !clear && (bit_cnt_q == 3'd7);
  assign word_match = (word == expected_q);

  lfsr_advance #(
    .STEPS (STEPS_PER_WORD),
    .TAPS  (TAPS)
  ) u_adv_expected (
    .state_i (expected_q),
    .state_o (expected_adv)
  );

`ifdef LFSR_RX_SELF_SYNC_EN
  logic locked_q, locked_d;

  // Gated by reset so the reset branch always loads from Seed, even if reset lands on
  // an edge that would otherwise complete a mismatching word.
  assign load_src = (reset && complete && !word_match) ? word : Seed;
  assign locked   = locked_q;
`else
  assign load_src = Seed;
  assign locked   = 1'b1;
`endif

  lfsr_advance #(
    .STEPS (STEPS_PER_WORD),
    .TAPS  (TAPS)
  ) u_adv_load (
    .state_i (load_src),
    .state_o (load_adv)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    expected_d = expected_q;
    err_d      = err_q;
`ifdef LFSR_RX_SELF_SYNC_EN
    locked_d   = locked_q;
`endif
    if (clear) begin
      // clear wins over a coincident in_valid: that bit is discarded.
      state_d    = StIdle;
      bit_cnt_d  = 3'd0;
      shreg_d    = '0;
      expected_d = load_adv;
      err_d      = 8'h00;
`ifdef LFSR_RX_SELF_SYNC_EN
      locked_d   = 1'b1;
`endif
    end else if (in_valid) begin
      shreg_d   = word;
      bit_cnt_d = bit_cnt_q + 3'd1;
      unique case (state_q)
        StIdle: state_d = StRecv;
        StRecv: if (bit_cnt_q == 3'd7) state_d = StIdle;
        default: state_d = StIdle;
      endcase
      if (complete) begin
        if (!word_match && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
`ifdef LFSR_RX_SELF_SYNC_EN
        expected_d = word_match ? expected_adv : load_adv;
        locked_d   = word_match;
`else
        expected_d = expected_adv;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= '0;
      expected_q   <= load_adv;
      err_q        <= 8'h00;
      data_out_q   <= '0;
      match_q      <= 1'b0;
      word_valid_q <= 1'b0;
`ifdef LFSR_RX_SELF_SYNC_EN
      locked_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      expected_q   <= expected_d;
      err_q        <= err_d;
      word_valid_q <= complete;
      if (complete) begin
        data_out_q <= word;
        match_q    <= word_match;
      end
`ifdef LFSR_RX_SELF_SYNC_EN
      locked_q     <= locked_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign word_valid = word_valid_q;
  assign match      = match_q;
  assign err_count  = err_q;

endmodule
